// File: rtl/pio_pkg.sv
// Shared definitions for the edge/level interrupting input PIO: register map,
// IRQ mode encodings and the debounce counter sizing helper.
package pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA = 3'd0,
        ADDR_SYNC = 3'd1,
        ADDR_MASK = 3'd2,
        ADDR_EDGE = 3'd3,
        ADDR_RISE = 3'd4,
        ADDR_FALL = 3'd5,
        ADDR_MODE = 3'd6,
        ADDR_RSVD = 3'd7
    } regAddrE;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

    // A zero-cycle debounce has no counter; report width 1 so callers never build a zero-width vector.
    function automatic int unsigned debCntWidth(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce_chan.sv
// One input channel: multi-flop synchroniser followed by an optional
// stable-count debouncer producing the filtered level.
module pio_debounce_chan
    import pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] syncChain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_o = syncChain_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : gBypass
        assign stable_o = sync_o;
    end else begin : gDebounce
        localparam int unsigned CW = debCntWidth(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] count_q, count_d;
        logic          stableBit_q, stableBit_d;

        // The flip happens on the edge that completes the run of differing cycles, so the count stops one short.
        always_comb begin
            count_d     = '0;
            stableBit_d = stableBit_q;
            if (sync_o != stableBit_q) begin
                if (count_q == CNT_LAST) begin
                    stableBit_d = sync_o;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                count_q     <= '0;
                stableBit_q <= 1'b0;
            end else begin
                count_q     <= count_d;
                stableBit_q <= stableBit_d;
            end
        end

        assign stable_o = stableBit_q;
    end

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with per-channel debounce, selectable rise/fall capture,
// write-1-to-clear edge register and a registered level-or-edge interrupt.
module pio_edge_irq_in
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = '1,
    parameter logic [WIDTH-1:0] FALL_EN_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] syncVec, stableVec;

    for (genvar i = 0; i < WIDTH; i++) begin : gChan
        pio_debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uChan (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (in_port[i]),
            .sync_o  (syncVec[i]),
            .stable_o(stableVec[i])
        );
    end

    logic [WIDTH-1:0] stableDly_q;
    logic [WIDTH-1:0] irqMask_q, irqMask_d;
    logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
    logic [WIDTH-1:0] riseEn_q, riseEn_d;
    logic [WIDTH-1:0] fallEn_q, fallEn_d;
    logic             irqMode_q, irqMode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wrEn;
    regAddrE          addrSel;
    logic [WIDTH-1:0] wrBits, clrMask, riseHit, fallHit, irqSrc;
    logic             unusedWdata;

    assign wrEn        = chipselect & ~write_n;
    assign addrSel     = regAddrE'(address);
    assign wrBits      = writedata[WIDTH-1:0];
    assign unusedWdata = ^writedata;

    assign riseHit = stableVec & ~stableDly_q & riseEn_q;
    assign fallHit = ~stableVec & stableDly_q & fallEn_q;
    assign irqSrc  = (irqMode_q == IRQ_MODE_EDGE) ? edgeCap_q : stableVec;

    always_comb begin
        irqMask_d  = irqMask_q;
        riseEn_d   = riseEn_q;
        fallEn_d   = fallEn_q;
        irqMode_d  = irqMode_q;
        clrMask    = '0;
        readdata_d = '0;

        if (wrEn) begin
            case (addrSel)
                ADDR_MASK: irqMask_d = wrBits;
                ADDR_EDGE: clrMask   = wrBits;
                ADDR_RISE: riseEn_d  = wrBits;
                ADDR_FALL: fallEn_d  = wrBits;
                ADDR_MODE: irqMode_d = writedata[0];
                default:   ;
            endcase
        end

        // A fresh edge overrides a simultaneous clear so no event is ever lost.
        edgeCap_d = (edgeCap_q & ~clrMask) | riseHit | fallHit;

        case (addrSel)
            ADDR_DATA: readdata_d = 32'(stableVec);
            ADDR_SYNC: readdata_d = 32'(syncVec);
            ADDR_MASK: readdata_d = 32'(irqMask_q);
            ADDR_EDGE: readdata_d = 32'(edgeCap_q);
            ADDR_RISE: readdata_d = 32'(riseEn_q);
            ADDR_FALL: readdata_d = 32'(fallEn_q);
            ADDR_MODE: readdata_d = 32'(irqMode_q);
            default:   readdata_d = '0;
        endcase

        irq_d = |(irqSrc & irqMask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stableDly_q <= '0;
            irqMask_q   <= '0;
            edgeCap_q   <= '0;
            riseEn_q    <= RISE_EN_RESET;
            fallEn_q    <= FALL_EN_RESET;
            irqMode_q   <= IRQ_MODE_LEVEL;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            stableDly_q <= stableVec;
            irqMask_q   <= irqMask_d;
            edgeCap_q   <= edgeCap_d;
            riseEn_q    <= riseEn_d;
            fallEn_q    <= fallEn_d;
            irqMode_q   <= irqMode_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Directed bench for the edge-IRQ input PIO: a debounced 4-bit instance plus
// 32-bit bypass and 8-bit instances sharing one bus and reset.
module tb_pio_edge_irq_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [3:0]  aIn;
    logic [31:0] aRd;
    logic        aIrq;
    logic [31:0] bIn;
    logic [31:0] bRd;
    logic        bIrq;
    logic [7:0]  cIn;
    logic [31:0] cRd;
    logic        cIrq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_edge_irq_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) uA (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(aIn),
        .readdata(aRd), .irq(aIrq)
    );

    pio_edge_irq_in #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) uB (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(bIn),
        .readdata(bRd), .irq(bIrq)
    );

    pio_edge_irq_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) uC (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(cIn),
        .readdata(cRd), .irq(cIrq)
    );

    typedef struct {
        string       name;
        logic        doWrite;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } vecT;

    vecT vecs[21];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic busRead(input logic [2:0] addr);
        address = addr;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vecT v);
        if (v.doWrite) busWrite(v.addr, v.wdata);
        busRead(v.addr);
        checkOutput(v.name, aRd, v.expRead);
    endtask

    initial begin
        int   hiCount;
        logic irqSeen;

        vecs[0]  = '{"rst_data", 1'b0, 3'd0, 32'h0, 32'h0};
        vecs[1]  = '{"rst_sync", 1'b0, 3'd1, 32'h0, 32'h0};
        vecs[2]  = '{"rst_mask", 1'b0, 3'd2, 32'h0, 32'h0};
        vecs[3]  = '{"rst_edge", 1'b0, 3'd3, 32'h0, 32'h0};
        vecs[4]  = '{"rst_rise", 1'b0, 3'd4, 32'h0, 32'hF};
        vecs[5]  = '{"rst_fall", 1'b0, 3'd5, 32'h0, 32'h0};
        vecs[6]  = '{"rst_mode", 1'b0, 3'd6, 32'h0, 32'h0};
        vecs[7]  = '{"rst_rsvd", 1'b0, 3'd7, 32'h0, 32'h0};
        vecs[8]  = '{"wr_mask",  1'b1, 3'd2, 32'hFFFF_FFF5, 32'h5};
        vecs[9]  = '{"wr_rise",  1'b1, 3'd4, 32'h0000_000A, 32'hA};
        vecs[10] = '{"wr_fall",  1'b1, 3'd5, 32'h0000_0003, 32'h3};
        vecs[11] = '{"wr_mode0", 1'b1, 3'd6, 32'hFFFF_FFFE, 32'h0};
        vecs[12] = '{"wr_mode1", 1'b1, 3'd6, 32'h0000_0003, 32'h1};
        vecs[13] = '{"wr_data",  1'b1, 3'd0, 32'h0000_000F, 32'h0};
        vecs[14] = '{"wr_sync",  1'b1, 3'd1, 32'h0000_000F, 32'h0};
        vecs[15] = '{"wr_rsvd",  1'b1, 3'd7, 32'h0000_000F, 32'h0};
        vecs[16] = '{"wr_edge",  1'b1, 3'd3, 32'h0000_000F, 32'h0};
        vecs[17] = '{"rs_mask",  1'b1, 3'd2, 32'h0, 32'h0};
        vecs[18] = '{"rs_rise",  1'b1, 3'd4, 32'hF, 32'hF};
        vecs[19] = '{"rs_fall",  1'b1, 3'd5, 32'h0, 32'h0};
        vecs[20] = '{"rs_mode",  1'b1, 3'd6, 32'h0, 32'h0};

        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        aIn        = '0;
        bIn        = '0;
        cIn        = '0;
        tick(2);
        reset = 1'b0;

        checkOutput("rst_irq", 32'(aIrq), 32'h0);
        for (int i = 0; i < 21; i++) applyStimulus(vecs[i]);

        // Glitch of two cycles on channel 1 must show on sync but never reach stable.
        busWrite(3'd2, 32'h2);
        busRead(3'd1);
        aIn[1]  = 1'b1;
        hiCount = 0;
        irqSeen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) aIn[1] = 1'b0;
            @(negedge clk);
            if (aRd[1]) hiCount++;
            irqSeen = irqSeen | aIrq;
        end
        checkOutput("glitch_sync_cycles", 32'(hiCount), 32'd2);
        checkOutput("glitch_irq", 32'(irqSeen), 32'h0);
        busRead(3'd0);
        checkOutput("glitch_stable", aRd, 32'h0);
        busRead(3'd3);
        checkOutput("glitch_edge", aRd, 32'h0);

        // Rising edge capture latency in edge mode.
        busWrite(3'd6, 32'h1);
        busWrite(3'd2, 32'h1);
        busRead(3'd3);
        aIn[0] = 1'b1;
        tick(6);
        checkOutput("rise_cap_early", aRd, 32'h0);
        checkOutput("rise_irq_early", 32'(aIrq), 32'h0);
        tick(1);
        checkOutput("rise_cap", aRd, 32'h1);
        checkOutput("rise_irq", 32'(aIrq), 32'h1);
        busWrite(3'd3, 32'h1);
        tick(1);
        checkOutput("rise_clr_irq", 32'(aIrq), 32'h0);

        aIn[0] = 1'b0;
        tick(10);
        busRead(3'd3);
        checkOutput("fall_ignored", aRd, 32'h0);
        aIn[0] = 1'b1;
        tick(10);
        busRead(3'd3);
        checkOutput("rise2_cap", aRd, 32'h1);
        aIn[0] = 1'b0;
        tick(10);

        // Clear lands on the same edge as a new rise: the set wins.
        aIn[0] = 1'b1;
        tick(5);
        address    = 3'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        busRead(3'd3);
        checkOutput("coll_keep", aRd, 32'h1);
        checkOutput("coll_irq", 32'(aIrq), 32'h1);
        busWrite(3'd3, 32'h1);
        checkOutput("clr_irq_hold", 32'(aIrq), 32'h1);
        tick(1);
        checkOutput("clr_irq_drop", 32'(aIrq), 32'h0);
        busRead(3'd3);
        checkOutput("clr_edge", aRd, 32'h0);

        // Level mode follows stable[2]; fall_en lets the fall capture too.
        busWrite(3'd6, 32'h0);
        busWrite(3'd2, 32'h4);
        busWrite(3'd5, 32'h4);
        aIn[2] = 1'b1;
        tick(5);
        checkOutput("lvl_irq_early", 32'(aIrq), 32'h0);
        tick(1);
        checkOutput("lvl_irq_high", 32'(aIrq), 32'h1);
        busWrite(3'd3, 32'h4);
        busRead(3'd0);
        checkOutput("lvl_stable", aRd, 32'h5);
        aIn[2] = 1'b0;
        tick(5);
        checkOutput("lvl_irq_hold", 32'(aIrq), 32'h1);
        tick(1);
        checkOutput("lvl_irq_low", 32'(aIrq), 32'h0);
        tick(2);
        busRead(3'd3);
        checkOutput("fall_cap", aRd, 32'h4);

        // A pin held high through reset appears as a rise after the normal latency.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        busRead(3'd3);
        checkOutput("rsthold_pre", aRd, 32'h0);
        busRead(3'd3);
        checkOutput("rsthold_cap", aRd, 32'h1);

        // 32-bit bypass instance, three sync stages.
        busWrite(3'd6, 32'h1);
        busWrite(3'd2, 32'h8000_0000);
        busRead(3'd0);
        bIn[31] = 1'b1;
        tick(3);
        checkOutput("w32_data_early", bRd, 32'h0);
        checkOutput("w32_irq_early", 32'(bIrq), 32'h0);
        tick(1);
        checkOutput("w32_data", bRd, 32'h8000_0000);
        checkOutput("w32_irq_mid", 32'(bIrq), 32'h0);
        tick(1);
        checkOutput("w32_irq", 32'(bIrq), 32'h1);
        busRead(3'd3);
        checkOutput("w32_edge", bRd, 32'h8000_0000);

        // Upper writedata bits are dropped on narrow instances.
        busWrite(3'd2, 32'hFFFF_FF5A);
        busRead(3'd2);
        checkOutput("w8_mask", cRd, 32'h5A);
        checkOutput("w4_mask", aRd, 32'hA);
        checkOutput("w32_mask", bRd, 32'hFFFF_FF5A);
        cIn = 8'hA5;
        tick(2);
        busRead(3'd1);
        checkOutput("w8_sync", cRd, 32'hA5);
        tick(2);
        busRead(3'd3);
        checkOutput("w8_edge", cRd, 32'hA5);
        checkOutput("w8_irq_off", 32'(cIrq), 32'h0);
        busWrite(3'd2, 32'h80);
        tick(1);
        checkOutput("w8_irq_on", 32'(cIrq), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
